// File: rtl/shouse_scr_pkg.sv
// Shared constants for the Splatter House C123 tilemap register block:
// register map offsets, field widths and layer counts.
package shouse_scr_pkg;

    // Register map offsets
    localparam int unsigned SCR_BASE  = 'h00;
    localparam int unsigned PRIO_BASE = 'h10;
    localparam int unsigned PAL_BASE  = 'h18;

    // Field widths
    localparam int unsigned SCR_W = 16;
    localparam int unsigned FLD_W = 3;

    // Disable flag position inside a priority register
    localparam int unsigned ENB_BIT = 3;

    // Layer counts
    localparam int unsigned NUM_SCR   = 4;
    localparam int unsigned NUM_LAYER = 6;

    // Register storage
    localparam int unsigned NUM_REGS = 32;
    typedef logic [7:0] mmr_byte_t;

endpackage

// File: rtl/shouse_scr_mmr.sv
// Memory-mapped register file for the Namco C123 tilemap controller.
// 32 byte registers written by the CPU, decoded continuously into per-layer
// scroll, priority, palette and disable fields, and readable on three
// independent combinational ports (CPU, IOCTL dump, debug status).
// Optional feature macro: SHOUSE_SCR_MMR_READBACK_EN enables CPU readback on
// dout; without it dout is tied to 0x00.
module shouse_scr_mmr
    import shouse_scr_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cs,
    input  logic [4:0]                        addr,
    input  logic                              rnw,
    input  logic [7:0]                        din,
    output logic [7:0]                        dout,
    output logic [NUM_SCR-1:0][SCR_W-1:0]     hscr,
    output logic [NUM_SCR-1:0][SCR_W-1:0]     vscr,
    output logic [NUM_LAYER-1:0][FLD_W-1:0]   pal,
    output logic [NUM_LAYER-1:0][FLD_W-1:0]   prio,
    output logic [NUM_LAYER-1:0]              enb,
    input  logic [4:0]                        ioctl_addr,
    output logic [7:0]                        ioctl_din,
    input  logic [7:0]                        debug_bus,
    output logic [7:0]                        st_dout
);

    mmr_byte_t mmr [NUM_REGS];

    // Register array: asynchronous clear, CPU byte write on the rising edge.
    // NOTE: this array is reset (unlike a RAM) because every decoded field
    // must read 0 the instant rst rises, so it maps to flops, not a macro.
    // NOTE: state is assigned with <= so all registers update together at
    // the edge and a same-cycle read still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mmr[i] <= 8'h00;
            end
        end else if (cs && !rnw) begin
            mmr[addr] <= din;
        end
    end

    // Scroll words: big-endian pairs, high byte at the lower address.
    for (genvar i = 0; i < NUM_SCR; i++) begin : g_scr
        localparam logic [4:0] BASE = 5'(SCR_BASE + 4 * i);
        assign hscr[i] = {mmr[BASE],        mmr[BASE + 5'd1]};
        assign vscr[i] = {mmr[BASE + 5'd2], mmr[BASE + 5'd3]};
    end

    // Per-layer priority / disable flag and palette bank.
    for (genvar j = 0; j < NUM_LAYER; j++) begin : g_layer
        localparam logic [4:0] PRIO_A = 5'(PRIO_BASE + j);
        localparam logic [4:0] PAL_A  = 5'(PAL_BASE + j);
        assign prio[j] = mmr[PRIO_A][FLD_W-1:0];
        assign enb[j]  = mmr[PRIO_A][ENB_BIT];
        assign pal[j]  = mmr[PAL_A][FLD_W-1:0];
    end

    // Dump and debug read ports are always live.
    assign ioctl_din = mmr[ioctl_addr];
    assign st_dout   = mmr[debug_bus[4:0]];

`ifdef SHOUSE_SCR_MMR_READBACK_EN
    // CPU readback ignores cs and rnw.
    assign dout = mmr[addr];

    logic unused_bits;
    assign unused_bits = ^debug_bus[7:5];
`else
    // Readback disabled: the CPU sees a constant zero.
    assign dout = 8'h00;

    logic unused_bits;
    assign unused_bits = ^{debug_bus[7:5], addr};
`endif

endmodule

// File: tb/tb_shouse_scr_mmr.sv
// Self-checking bench for shouse_scr_mmr. A byte-array model of the register
// file is updated on every accepted write; expected fields are computed from
// the register map with plain arithmetic.
module tb_shouse_scr_mmr;

`ifdef SHOUSE_SCR_MMR_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 cs = 1'b0;
    logic [4:0]           addr = '0;
    logic                 rnw = 1'b1;
    logic [7:0]           din = '0;
    logic [7:0]           dout;
    logic [3:0][15:0]     hscr;
    logic [3:0][15:0]     vscr;
    logic [5:0][2:0]      pal;
    logic [5:0][2:0]      prio;
    logic [5:0]           enb;
    logic [4:0]           ioctl_addr = '0;
    logic [7:0]           ioctl_din;
    logic [7:0]           debug_bus = '0;
    logic [7:0]           st_dout;

    int checks = 0;
    int passes = 0;

    logic [7:0] model [32];

    shouse_scr_mmr dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .addr       (addr),
        .rnw        (rnw),
        .din        (din),
        .dout       (dout),
        .hscr       (hscr),
        .vscr       (vscr),
        .pal        (pal),
        .prio       (prio),
        .enb        (enb),
        .ioctl_addr (ioctl_addr),
        .ioctl_din  (ioctl_din),
        .debug_bus  (debug_bus),
        .st_dout    (st_dout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0][15:0] exp_hscr();
        logic [3:0][15:0] r;
        for (int i = 0; i < 4; i++) r[i] = model[4*i] * 256 + model[4*i+1];
        return r;
    endfunction

    function automatic logic [3:0][15:0] exp_vscr();
        logic [3:0][15:0] r;
        for (int i = 0; i < 4; i++) r[i] = model[4*i+2] * 256 + model[4*i+3];
        return r;
    endfunction

    function automatic logic [5:0][2:0] exp_prio();
        logic [5:0][2:0] r;
        for (int j = 0; j < 6; j++) r[j] = 3'(model[16+j] % 8);
        return r;
    endfunction

    function automatic logic [5:0] exp_enb();
        logic [5:0] r;
        for (int j = 0; j < 6; j++) r[j] = 1'((model[16+j] / 8) % 2);
        return r;
    endfunction

    function automatic logic [5:0][2:0] exp_pal();
        logic [5:0][2:0] r;
        for (int j = 0; j < 6; j++) r[j] = 3'(model[24+j] % 8);
        return r;
    endfunction

    function automatic logic [7:0] exp_dout(input logic [4:0] a);
        return READBACK ? model[a] : 8'h00;
    endfunction

    // ---------------- stimulus ----------------
    task automatic write_reg(input logic [4:0] a, input logic [7:0] d, input logic c);
        @(negedge clk);
        cs = c; rnw = 1'b0; addr = a; din = d;
        @(posedge clk);
        if (c && !rst) model[a] = d;
        #1;
        cs = 1'b0; rnw = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        // a write attempted during reset must be ignored
        write_reg(5'd5, 8'hFF, 1'b1);
        addr = 5'd5; ioctl_addr = 5'd5; debug_bus = 8'h05;
        #1;
        checks++; if (hscr !== exp_hscr()) $display("FAIL reset_hscr got %h want %h", hscr, exp_hscr()); else passes++;
        checks++; if (vscr !== exp_vscr()) $display("FAIL reset_vscr got %h want %h", vscr, exp_vscr()); else passes++;
        checks++; if (prio !== exp_prio()) $display("FAIL reset_prio got %h want %h", prio, exp_prio()); else passes++;
        checks++; if (pal !== exp_pal()) $display("FAIL reset_pal got %h want %h", pal, exp_pal()); else passes++;
        checks++; if (enb !== exp_enb()) $display("FAIL reset_enb got %h want %h", enb, exp_enb()); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout got %h want 00", dout); else passes++;
        checks++; if (ioctl_din !== 8'h00) $display("FAIL reset_ioctl got %h want 00", ioctl_din); else passes++;
        checks++; if (st_dout !== 8'h00) $display("FAIL reset_st got %h want 00", st_dout); else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scroll();
        write_reg(5'h04, 8'h12, 1'b1);
        write_reg(5'h05, 8'h34, 1'b1);
        write_reg(5'h06, 8'hAB, 1'b1);
        write_reg(5'h07, 8'hCD, 1'b1);
        checks++; if (hscr[1] !== 16'h1234) $display("FAIL scroll_h1 got %h want 1234", hscr[1]); else passes++;
        checks++; if (vscr[1] !== 16'hABCD) $display("FAIL scroll_v1 got %h want abcd", vscr[1]); else passes++;
        checks++; if (hscr !== exp_hscr()) $display("FAIL scroll_hall got %h want %h", hscr, exp_hscr()); else passes++;
        checks++; if (vscr !== exp_vscr()) $display("FAIL scroll_vall got %h want %h", vscr, exp_vscr()); else passes++;
    endtask

    task automatic test_fields();
        write_reg(5'h12, 8'h0D, 1'b1);
        checks++; if (prio[2] !== 3'd5) $display("FAIL prio2 got %0d want 5", prio[2]); else passes++;
        checks++; if (enb[2] !== 1'b1) $display("FAIL enb2 got %b want 1", enb[2]); else passes++;
        write_reg(5'h1D, 8'h06, 1'b1);
        checks++; if (pal[5] !== 3'd6) $display("FAIL pal5 got %0d want 6", pal[5]); else passes++;
        // upper bits stored but not decoded
        write_reg(5'h13, 8'hF5, 1'b1);
        ioctl_addr = 5'h13; #1;
        checks++; if (prio[3] !== 3'd5) $display("FAIL prio3 got %0d want 5", prio[3]); else passes++;
        checks++; if (enb[3] !== 1'b0) $display("FAIL enb3 got %b want 0", enb[3]); else passes++;
        checks++; if (ioctl_din !== 8'hF5) $display("FAIL prio3_readback got %h want f5", ioctl_din); else passes++;
        write_reg(5'h1A, 8'hF9, 1'b1);
        debug_bus = 8'h1A; #1;
        checks++; if (pal[2] !== 3'd1) $display("FAIL pal2 got %0d want 1", pal[2]); else passes++;
        checks++; if (st_dout !== 8'hF9) $display("FAIL pal2_readback got %h want f9", st_dout); else passes++;
        // unused addresses store and read back but drive no field
        write_reg(5'h17, 8'hFF, 1'b1);
        write_reg(5'h1F, 8'hFF, 1'b1);
        ioctl_addr = 5'h17; debug_bus = 8'h1F; #1;
        checks++; if (ioctl_din !== 8'hFF) $display("FAIL unused17 got %h want ff", ioctl_din); else passes++;
        checks++; if (st_dout !== 8'hFF) $display("FAIL unused1f got %h want ff", st_dout); else passes++;
        checks++; if (prio !== exp_prio()) $display("FAIL prio_all got %h want %h", prio, exp_prio()); else passes++;
        checks++; if (enb !== exp_enb()) $display("FAIL enb_all got %h want %h", enb, exp_enb()); else passes++;
        checks++; if (pal !== exp_pal()) $display("FAIL pal_all got %h want %h", pal, exp_pal()); else passes++;
    endtask

    task automatic test_read_ports();
        for (int k = 0; k < 32; k++) write_reg(5'(k), 8'(k) ^ 8'h5A, 1'b1);
        for (int k = 0; k < 32; k++) begin
            addr = 5'(k);
            ioctl_addr = 5'(31 - k);
            debug_bus = {3'($urandom_range(7)), 5'(k)};
            #1;
            checks++; if (dout !== (READBACK ? (8'(k) ^ 8'h5A) : 8'h00))
                $display("FAIL sweep_dout a=%0d got %h want %h", k, dout, READBACK ? (8'(k) ^ 8'h5A) : 8'h00);
            else passes++;
            checks++; if (ioctl_din !== (8'(31 - k) ^ 8'h5A))
                $display("FAIL sweep_ioctl a=%0d got %h want %h", 31 - k, ioctl_din, 8'(31 - k) ^ 8'h5A);
            else passes++;
            checks++; if (st_dout !== (8'(k) ^ 8'h5A))
                $display("FAIL sweep_st a=%0d got %h want %h", k, st_dout, 8'(k) ^ 8'h5A);
            else passes++;
        end
        debug_bus = 8'hE3; #1;
        checks++; if (st_dout !== 8'h59) $display("FAIL st_high_bits got %h want 59", st_dout); else passes++;
        checks++; if (hscr !== exp_hscr()) $display("FAIL sweep_hscr got %h want %h", hscr, exp_hscr()); else passes++;
    endtask

    task automatic test_cs_gating();
        write_reg(5'h10, 8'h07, 1'b0);
        ioctl_addr = 5'h10; #1;
        checks++; if (ioctl_din !== 8'h4A) $display("FAIL cs_gate got %h want 4a", ioctl_din); else passes++;
        checks++; if (prio !== exp_prio()) $display("FAIL cs_gate_prio got %h want %h", prio, exp_prio()); else passes++;
    endtask

    task automatic test_read_during_write();
        logic [7:0] old_v;
        old_v = model[9];
        @(negedge clk);
        cs = 1'b1; rnw = 1'b0; addr = 5'd9; din = ~old_v;
        ioctl_addr = 5'd9; debug_bus = 8'h09;
        #1;
        checks++; if (ioctl_din !== old_v) $display("FAIL rdw_old_ioctl got %h want %h", ioctl_din, old_v); else passes++;
        checks++; if (dout !== exp_dout(5'd9)) $display("FAIL rdw_old_dout got %h want %h", dout, exp_dout(5'd9)); else passes++;
        @(posedge clk);
        model[9] = ~old_v;
        #1;
        cs = 1'b0; rnw = 1'b1;
        checks++; if (st_dout !== ~old_v) $display("FAIL rdw_new_st got %h want %h", st_dout, ~old_v); else passes++;
        checks++; if (dout !== exp_dout(5'd9)) $display("FAIL rdw_new_dout got %h want %h", dout, exp_dout(5'd9)); else passes++;
        checks++; if (vscr !== exp_vscr()) $display("FAIL rdw_vscr got %h want %h", vscr, exp_vscr()); else passes++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int n = 0; n < 300; n++) begin
            logic [4:0] a;
            logic [7:0] d;
            logic       c;
            a = 5'($urandom_range(31));
            d = 8'($urandom_range(255));
            c = ($urandom_range(3) != 0);
            write_reg(a, d, c);
            addr = 5'($urandom_range(31));
            ioctl_addr = 5'($urandom_range(31));
            debug_bus = 8'($urandom_range(255));
            #1;
            checks++;
            if (hscr !== exp_hscr() || vscr !== exp_vscr() || prio !== exp_prio() ||
                pal !== exp_pal() || enb !== exp_enb() || dout !== exp_dout(addr) ||
                ioctl_din !== model[ioctl_addr] || st_dout !== model[debug_bus[4:0]]) begin
                if (errs < 5)
                    $display("FAIL random n=%0d hscr=%h/%h vscr=%h/%h prio=%h/%h pal=%h/%h enb=%h/%h dout=%h/%h io=%h/%h st=%h/%h",
                             n, hscr, exp_hscr(), vscr, exp_vscr(), prio, exp_prio(), pal, exp_pal(),
                             enb, exp_enb(), dout, exp_dout(addr), ioctl_din, model[ioctl_addr],
                             st_dout, model[debug_bus[4:0]]);
                errs++;
            end else passes++;
        end
    endtask

    task automatic test_async_reset();
        write_reg(5'h00, 8'hA5, 1'b1);
        write_reg(5'h11, 8'h0F, 1'b1);
        ioctl_addr = 5'h00; debug_bus = 8'h11;
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        #1;  // still before the next rising edge
        checks++; if (hscr !== 64'h0) $display("FAIL async_hscr got %h want 0", hscr); else passes++;
        checks++; if (ioctl_din !== 8'h00) $display("FAIL async_ioctl got %h want 00", ioctl_din); else passes++;
        checks++; if (st_dout !== 8'h00) $display("FAIL async_st got %h want 00", st_dout); else passes++;
        checks++; if (enb !== 6'h0) $display("FAIL async_enb got %h want 00", enb); else passes++;
        @(negedge clk);
        rst = 1'b0;
        write_reg(5'h03, 8'h3C, 1'b1);
        checks++; if (hscr !== exp_hscr() || vscr !== exp_vscr())
            $display("FAIL post_reset_write got %h/%h want %h/%h", hscr, vscr, exp_hscr(), exp_vscr());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_scroll();
        test_fields();
        test_read_ports();
        test_cs_gating();
        test_read_during_write();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shouse_scr_mmr.md
# shouse_scr_mmr

Memory-mapped register file for the Namco C123 tilemap controller in the Splatter House core. The CPU writes 32 byte registers that set per-layer scroll, priority, palette and enable. The scroll/tilemap renderer consumes the decoded fields continuously. The same bytes are readable from the CPU bus, the IOCTL dump port and the debug status port.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cs  in  1  CPU chip select for this register block
- addr  in  5  CPU byte address, 0x00–0x1F
- rnw  in  1  1 = read, 0 = write
- din  in  8  CPU write data
- dout  out  8  CPU read data
- hscr  out  4×16 (packed [3:0][15:0])  horizontal scroll, scroll layers 0–3
- vscr  out  4×16 (packed [3:0][15:0])  vertical scroll, scroll layers 0–3
- pal  out  6×3 (packed [5:0][2:0])  palette bank, layers 0–5
- prio  out  6×3 (packed [5:0][2:0])  priority, layers 0–5 (7 = top)
- enb  out  6  per-layer disable flag, layers 0–5 (1 = layer disabled)
- ioctl_addr  in  5  dump byte address
- ioctl_din  out  8  dump read data
- debug_bus  in  8  debug selector
- st_dout  out  8  debug status byte

## Operation
- Storage: 32 × 8-bit registers, mmr[0..31]. All registers reset to 0x00.
- Write: on a rising clk with cs=1 and rnw=0, din is stored into mmr[addr]. Every address is writable. There are no side effects.
- Field decode, all purely combinational from mmr. Words are big-endian (high byte at the lower address).
  - Scroll layer i, i = 0..3:
    - hscr[i] = {mmr[4i], mmr[4i+1]}
    - vscr[i] = {mmr[4i+2], mmr[4i+3]}
  - Layer j, j = 0..5, register 0x10+j:
    - prio[j] = mmr[0x10+j][2:0]
    - enb[j] = mmr[0x10+j][3]
  - Layer j, j = 0..5, register 0x18+j:
    - pal[j] = mmr[0x18+j][2:0]
  - Unused bits and addresses 0x16, 0x17, 0x1E and 0x1F are stored and read back, but drive no field.
- Reads, all combinational:
  - dout = mmr[addr], independent of cs and rnw.
  - ioctl_din = mmr[ioctl_addr].
  - st_dout = mmr[debug_bus[4:0]]; debug_bus[7:5] are ignored.
- All three read ports are independent and may address the same register at once.

## Timing
- A write lands at the clk edge. Decoded outputs and all read ports show the new value right after that edge; no extra pipeline stage.
- Read latency is 0 cycles (combinational).
- A read and a write to the same address in the same cycle return the old value until the edge.
- While rst is asserted, every output derived from mmr reads 0. Writes are ignored during reset.
- Reset asserted mid-frame clears the registers immediately, without waiting for a clock.
- Address wrap does not apply: the 5-bit address covers exactly 32 registers.

## Configuration
- Macro SHOUSE_SCR_MMR_READBACK_EN.
- Defined: dout = mmr[addr] as described in Operation.
- Not defined: dout is tied to 0x00.
- The macro does not affect ioctl_din, st_dout or any decoded field.

## Structure
- Shared package shouse_scr_pkg holds:
  - register offset constants: SCR_BASE=0x00, PRIO_BASE=0x10, PAL_BASE=0x18
  - field widths: 16-bit scroll, 3-bit priority/palette
  - bit position of the disable flag in the priority register: ENB_BIT=3
  - layer counts: 4 scroll layers, 6 total layers
- No sub-module. This is a single flat register array plus decode.

## Test plan
- Reset: pulse rst → all hscr/vscr = 0, prio = pal = 0, enb = 0, dout = ioctl_din = st_dout = 0x00.
- Scroll write: write 0x12 to 0x04, 0x34 to 0x05, 0xAB to 0x06, 0xCD to 0x07 → hscr[1] = 0x1234, vscr[1] = 0xABCD, other scrolls still 0.
- Priority/enable/palette:
  - write 0x0D to 0x12 → prio[2] = 5, enb[2] = 1
  - write 0x06 to 0x1D → pal[5] = 6
  - bits above those fields are ignored by decode but read back intact.
- Read ports: fill mmr[k] = k ^ 0x5A for all 32 addresses, then sweep addr, ioctl_addr and debug_bus[4:0] → each port returns k ^ 0x5A. With debug_bus = 0xE3 → st_dout = mmr[3].
- cs gating: drive addr = 0x10, rnw = 0, din = 0x07 with cs = 0 → mmr[0x10] unchanged.
- Macro off: same writes as the read-port sweep → dout stays 0x00 while ioctl_din still returns the data.
